// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache-side request ports and the shared main-memory port.
// Latency: none; plain wires shared by the arbiter and its surroundings.
// Backpressure: requesters hold their command until their rdy pulse; memory has no stall.
// Modports: slave = arbiter side (takes requests, drives memory command),
//           master = environment side (cache controllers + memory model).
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req0_strobe;
    logic          req0_rw;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_rdy;
    logic [DW-1:0] req0_rdata;

    logic          req1_strobe;
    logic          req1_rw;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_rdy;
    logic [DW-1:0] req1_rdata;

    logic          mem_strobe;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_strobe, req0_rw, req0_addr, req0_wdata,
        output req0_rdy, req0_rdata,
        input  req1_strobe, req1_rw, req1_addr, req1_wdata,
        output req1_rdy, req1_rdata,
        output mem_strobe, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_strobe, req0_rw, req0_addr, req0_wdata,
        input  req0_rdy, req0_rdata,
        output req1_strobe, req1_rw, req1_addr, req1_wdata,
        input  req1_rdy, req1_rdata,
        input  mem_strobe, mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache (port 0) and D-cache (port 1), round-robin on ties.
// Latency: request sampled in cycle 0, mem_strobe in cycle 1, rdy in cycle MEM_LAT+2; one transaction per MEM_LAT+3 cycles.
// Backpressure: one transaction at a time; the other port's strobe simply waits until the arbiter returns to IDLE.
// Ports: clk, reset_n (async active-low), bus (slave side of mem_port_arbiter_if),
//        busy (state != IDLE), grant (owning port, meaningful while busy).
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MEM_LAT = 4,   // 1..15
    parameter int CW      = 4    // 2**CW > MEM_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          grant_q;
    logic          last_grant;
    logic          cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          any_req;
    logic          pick;

    // Winner for an IDLE cycle: the lone requester, or on a tie the port that did not go last.
    always_comb begin
        any_req = bus.req0_strobe | bus.req1_strobe;
        pick    = bus.req1_strobe;
        if (bus.req0_strobe && bus.req1_strobe) begin
            pick = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command, counter and per-port read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            grant_q    <= 1'b0;
            last_grant <= 1'b1;   // port 0 wins the first tie after reset
            cmd_rw     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q   <= pick;
                        cmd_rw    <= pick ? bus.req1_rw    : bus.req0_rw;
                        cmd_addr  <= pick ? bus.req1_addr  : bus.req0_addr;
                        cmd_wdata <= pick ? bus.req1_wdata : bus.req0_wdata;
                    end
                end
                ISSUE: cnt <= LAT_M1;
                WAIT: begin
                    // cnt runs MEM_LAT-1 .. 0, so WAIT lasts exactly MEM_LAT cycles and
                    // the capture lands in the cycle memory data is valid.
                    if (cnt == '0) begin
                        if (!cmd_rw) begin
                            if (grant_q) begin
                                rdata1 <= bus.mem_rdata;
                            end else begin
                                rdata0 <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: last_grant <= grant_q;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign bus.mem_strobe = (state == ISSUE);
    assign bus.mem_rw     = cmd_rw;
    assign bus.mem_addr   = cmd_addr;
    assign bus.mem_wdata  = cmd_wdata;
    assign bus.req0_rdy   = (state == DONE) && !grant_q;
    assign bus.req1_rdy   = (state == DONE) &&  grant_q;
    assign bus.req0_rdata = rdata0;
    assign bus.req1_rdata = rdata1;
    assign busy           = (state != IDLE);
    assign grant          = grant_q;

endmodule
